// File: rtl/deserializador_pkg.sv
// Shared definitions for the serial-to-parallel collector.
// Optional build macro: DESER_PARITY_EN (adds a trailing even-parity bit per frame).
package deserializador_pkg;

    // Bit order of the incoming serial stream
    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } dir_t;

    // Collector state
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Shift-register operating modes used by the upstream serializer
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PUSH  = 2'd1,
        CYCLE = 2'd2
    } mode_t;

endpackage

// File: rtl/ranura_salida.sv
// One-word output slot: holds a completed word until consumed, flags overflow.
// Optional build macro: DESER_PARITY_EN (carries a parity-error flag with the word).
module ranura_salida
    import deserializador_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             CLR,
    input  logic             READY,
    input  logic             DONE,
    input  logic [WIDTH-1:0] WORD,
`ifdef DESER_PARITY_EN
    input  logic             PAR_BAD,
    output logic             PAR_ERR,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             OVF
);

    // Accept a completed word when the slot is free or being drained, else drop it and flag
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            Q     <= '0;
            VALID <= 1'b0;
            OVF   <= 1'b0;
`ifdef DESER_PARITY_EN
            PAR_ERR <= 1'b0;
`endif
        end else if (CLR) begin
            VALID <= 1'b0;
            OVF   <= 1'b0;
`ifdef DESER_PARITY_EN
            PAR_ERR <= 1'b0;
`endif
        end else if (DONE) begin
            if (!VALID || READY) begin
                Q     <= WORD;
                VALID <= 1'b1;
`ifdef DESER_PARITY_EN
                PAR_ERR <= PAR_BAD;
`endif
            end else begin
                OVF <= 1'b1;
            end
        end else if (VALID && READY) begin
            VALID <= 1'b0;
        end
    end

endmodule

// File: rtl/deserializador.sv
// Serial-to-parallel collector with VALID/READY output slot and sticky overflow.
// Optional build macro: DESER_PARITY_EN (frame gets one extra even-parity bit, PAR_ERR port).
module deserializador
    import deserializador_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic             S_IN,
    input  logic             DIR,
    input  logic             CLR,
    input  logic             READY,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             OVF,
`ifdef DESER_PARITY_EN
    output logic             PAR_ERR,
`endif
    output logic [CNT_W-1:0] COUNT
);

`ifdef DESER_PARITY_EN
    // Final sampled bit of the frame is the parity bit, which is never shifted in
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt, shifted, word;
    logic [CNT_W-1:0] count_nxt;
    logic             done;
`ifdef DESER_PARITY_EN
    logic             par_bad;
`endif

    // Shift/count datapath and collector next-state
    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        count_nxt = COUNT;
        shifted   = (DIR == LSB_FIRST) ? {S_IN, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], S_IN};
        done      = ENB && (COUNT == LAST);
`ifdef DESER_PARITY_EN
        word      = sh;
        par_bad   = (^sh) ^ S_IN;
`else
        word      = shifted;
`endif

        case (state)
            ST_IDLE:    if (ENB && !done) state_nxt = ST_COLLECT;
            ST_COLLECT: if (done)         state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase

        if (CLR) begin
            state_nxt = ST_IDLE;
            sh_nxt    = '0;
            count_nxt = '0;
        end else if (done) begin
            sh_nxt    = '0;
            count_nxt = '0;
        end else if (ENB) begin
            sh_nxt    = shifted;
            count_nxt = COUNT + 1'b1;
        end
    end

    // Collector state, shift register and bit counter
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state <= ST_IDLE;
            sh    <= '0;
            COUNT <= '0;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            COUNT <= count_nxt;
        end
    end

    ranura_salida #(
        .WIDTH (WIDTH)
    ) u_slot (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .CLR     (CLR),
        .READY   (READY),
        .DONE    (done),
        .WORD    (word),
`ifdef DESER_PARITY_EN
        .PAR_BAD (par_bad),
        .PAR_ERR (PAR_ERR),
`endif
        .Q       (Q),
        .VALID   (VALID),
        .OVF     (OVF)
    );

endmodule

// File: tb/tb_deserializador.sv
// Self-checking bench for deserializador: vector table plus scoreboard of accepted words.
// Honours DESER_PARITY_EN (parity frames and PAR_ERR checks).
module tb_deserializador;

    localparam int W = 32;
`ifdef DESER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         CLK = 1'b0;
    logic         RESET_L = 1'b0;
    logic         ENB = 1'b0;
    logic         S_IN = 1'b0;
    logic         DIR = 1'b0;
    logic         CLR = 1'b0;
    logic         READY = 1'b1;
    logic [W-1:0] Q;
    logic         VALID;
    logic         OVF;
    logic [5:0]   COUNT;
`ifdef DESER_PARITY_EN
    logic         PAR_ERR;
`endif

    always #5 CLK = ~CLK;

    deserializador #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .ENB     (ENB),
        .S_IN    (S_IN),
        .DIR     (DIR),
        .CLR     (CLR),
        .READY   (READY),
        .Q       (Q),
        .VALID   (VALID),
        .OVF     (OVF),
`ifdef DESER_PARITY_EN
        .PAR_ERR (PAR_ERR),
`endif
        .COUNT   (COUNT)
    );

    typedef struct {
        logic [W-1:0] w;
        logic         perr;
    } exp_t;

    typedef struct {
        logic [W-1:0] w;
        logic         dir;
        int           gap_at;
        int           gap_len;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[5];
    int   rises[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard consumer: a word is taken at the next edge when VALID and READY are both high
    always @(negedge CLK) begin
        if (RESET_L) begin
            if (VALID && !prev_valid) rises.push_back(cyc);
            if (VALID && READY) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got word %0h expected no word", Q);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_q", Q, mon_e.w);
`ifdef DESER_PARITY_EN
                    chk("sb_par", PAR_ERR, mon_e.perr);
`endif
                end
            end
        end
        prev_valid = VALID;
    end

    task automatic send_word(input logic [W-1:0] w, input logic d, input int gap_at,
                             input int gap_len, input bit push, input bit bad_par);
        exp_t e;
        e.w    = w;
        e.perr = bad_par;
        for (int i = 0; i < W; i++) begin
            DIR  = d;
            ENB  = 1'b1;
            S_IN = d ? w[i] : w[W-1-i];
`ifndef DESER_PARITY_EN
            if (i == W - 1 && push) sb.push_back(e);
`endif
            tick();
            if (gap_len > 0 && i + 1 == gap_at) begin
                ENB = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    chk("gap_count", COUNT, gap_at);
                end
            end
        end
`ifdef DESER_PARITY_EN
        ENB  = 1'b1;
        S_IN = (^w) ^ bad_par;
        if (push) sb.push_back(e);
        tick();
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{w: 32'hAAAAAAAA, dir: 1'b1, gap_at: 10, gap_len: 3};
        vecs[1] = '{w: 32'h00000001, dir: 1'b0, gap_at: 0,  gap_len: 0};
        vecs[2] = '{w: 32'h80000000, dir: 1'b1, gap_at: 0,  gap_len: 0};
        vecs[3] = '{w: 32'hFFFFFFFF, dir: 1'b0, gap_at: 31, gap_len: 2};
        vecs[4] = '{w: 32'h12345678, dir: 1'b1, gap_at: 1,  gap_len: 5};

        // Reset state
        repeat (2) tick();
        chk("rst_q", Q, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_count", COUNT, 0);
        RESET_L = 1'b1;
        tick();

        // MSB-first word, visible right after the last bit's edge, drained next edge
        READY = 1'b1;
        send_word(32'hDDDDDDDD, 1'b0, 0, 0, 1'b1, 1'b0);
        chk("t1_valid", VALID, 1);
        chk("t1_q", Q, 32'hDDDDDDDD);
        chk("t1_count", COUNT, 0);
        ENB = 1'b0;
        tick();
        chk("t1_valid_drop", VALID, 0);

        // Vector table: orders, gaps, edge patterns
        foreach (vecs[k]) begin
            send_word(vecs[k].w, vecs[k].dir, vecs[k].gap_at, vecs[k].gap_len, 1'b1, 1'b0);
            ENB = 1'b0;
            chk("vec_q", Q, vecs[k].w);
            chk("vec_valid", VALID, 1);
            tick();
        end

        // Overflow while the slot is full, then CLR
        READY = 1'b0;
        send_word(32'h66666666, 1'b0, 0, 0, 1'b0, 1'b0);
        send_word(32'h12345678, 1'b0, 0, 0, 1'b0, 1'b0);
        ENB = 1'b0;
        tick();
        chk("ovf_q", Q, 32'h66666666);
        chk("ovf_valid", VALID, 1);
        chk("ovf_flag", OVF, 1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("clr_valid", VALID, 0);
        chk("clr_ovf", OVF, 0);
        chk("clr_q_hold", Q, 32'h66666666);
        READY = 1'b1;
        tick();

        // Back-to-back words, ENB held high throughout
        rises.delete();
        send_word(32'h01234567, 1'b0, 0, 0, 1'b1, 1'b0);
        send_word(32'h89ABCDEF, 1'b1, 0, 0, 1'b1, 1'b0);
        send_word(32'h0F0F0F0F, 1'b0, 0, 0, 1'b1, 1'b0);
        ENB = 1'b0;
        repeat (2) tick();
        chk("b2b_pulses", rises.size(), 3);
        if (rises.size() >= 3) begin
            chk("b2b_gap1", rises[1] - rises[0], FRAME);
            chk("b2b_gap2", rises[2] - rises[1], FRAME);
        end
        chk("b2b_ovf", OVF, 0);

        // Asynchronous reset mid-word
        for (int i = 0; i < 17; i++) begin
            DIR  = 1'b0;
            ENB  = 1'b1;
            S_IN = i[0];
            tick();
        end
        ENB = 1'b0;
        chk("pre_rst_count", COUNT, 17);
        #2;
        RESET_L = 1'b0;
        #1;
        chk("arst_q", Q, 0);
        chk("arst_valid", VALID, 0);
        chk("arst_ovf", OVF, 0);
        chk("arst_count", COUNT, 0);
        tick();
        RESET_L = 1'b1;
        tick();
        send_word(32'hCAFEF00D, 1'b0, 0, 0, 1'b1, 1'b0);
        ENB = 1'b0;
        chk("post_rst_q", Q, 32'hCAFEF00D);
        chk("post_rst_valid", VALID, 1);
        tick();

`ifdef DESER_PARITY_EN
        // Parity bit 0 on an odd-weight word is an error; parity bit 1 is clean
        send_word(32'h00000001, 1'b0, 0, 0, 1'b1, 1'b1);
        ENB = 1'b0;
        chk("par_bad", PAR_ERR, 1);
        chk("par_bad_valid", VALID, 1);
        tick();
        send_word(32'h00000001, 1'b0, 0, 0, 1'b1, 1'b0);
        ENB = 1'b0;
        chk("par_ok", PAR_ERR, 0);
        tick();
`endif

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/deserializador.md
Name: deserializador

Overview:
- Downstream consumer of the 32-bit shift register's serial output (`S_OUT`).
- Collects one bit per enabled clock into a word and presents completed words on a parallel output.
- Handshake is VALID/READY, with a one-word output buffer, so collection continues while a word waits.
- Reports overflow when a finished word cannot be buffered.

Parameters:
- WIDTH, 32, word length in bits.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH (and > WIDTH+1 with parity).

Ports:
- CLK  input  1  rising-edge clock.
- RESET_L  input  1  asynchronous active-low reset.
- ENB  input  1  sample S_IN on this edge.
- S_IN  input  1  serial data, driven from the shift register's S_OUT.
- DIR  input  1  bit order: 0 = MSB first (left-shift source), 1 = LSB first (right-shift source).
- CLR  input  1  synchronous abort of the partial word and the output slot.
- READY  input  1  consumer accepts Q this edge when VALID=1.
- Q  output  WIDTH  completed word.
- VALID  output  1  Q holds an unconsumed word.
- OVF  output  1  sticky overflow flag.
- COUNT  output  CNT_W  bits collected in the current word.
- PAR_ERR  output  1  parity flag for Q; present only with PARITY_EN.

Behaviour:
- Reset (RESET_L=0, async): shift reg sh=0, COUNT=0, Q=0, VALID=0, OVF=0, PAR_ERR=0, collector state=IDLE.
- Collector FSM, IDLE/COLLECT:
  - IDLE→COLLECT on the first ENB=1 edge.
  - COLLECT→IDLE on the edge that samples the last bit of a frame.
  - COLLECT→IDLE on CLR.
- Bit sampling, when ENB=1:
  - DIR=0: sh <= {sh[WIDTH-2:0],S_IN}.
  - DIR=1: sh <= {S_IN,sh[WIDTH-1:1]}.
  - COUNT increments.
  - DIR is sampled per bit. Changing DIR mid-word is legal and not flagged; the resulting word is undefined-by-design.
- ENB=0: sh and COUNT hold. Gaps of any length inside a word are allowed.
- Word completion, on the edge that samples bit WIDTH (COUNT==WIDTH-1 and ENB=1):
  - The assembled word, including that bit, is the completed word.
  - COUNT returns to 0 and sh clears.
  - Latency: VALID/Q update on that same edge, so they are visible the cycle after the last bit is presented.
- Output slot, evaluated on each edge:
  - Completion, slot empty or (VALID&READY): Q <= word, VALID=1.
  - Completion, VALID=1 and READY=0: word is dropped, Q unchanged, OVF <= 1.
  - No completion, VALID&READY: VALID <= 0, Q holds its last value.
- OVF is sticky and cleared only by reset or CLR.
- CLR (sync) has priority over ENB and READY: sh=0, COUNT=0, VALID=0, OVF=0, PAR_ERR=0, state=IDLE. Q holds.
- Reset mid-word discards the partial word; the next word starts from bit 0.
- Back-to-back words with ENB held high and READY=1 sustain one word per WIDTH cycles with no bubble.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 bits; the final bit is even parity over the WIDTH data bits.
  - The parity bit is not shifted into sh.
  - Completion occurs at COUNT==WIDTH.
  - PAR_ERR is registered with Q: 1 if data XOR parity bit ≠ 0. It follows the same load/drop rules as Q.
- Undefined: frame is WIDTH bits and the PAR_ERR port is absent.

Decomposition:
- Shared definitions.v holds:
  - `MSB_FIRST` (1'b0) and `LSB_FIRST` (1'b1) direction constants.
  - `ST_IDLE` and `ST_COLLECT` state encodings.
  - Alongside the existing `LOAD`/`PUSH`/`CYCLE` mode defines.
- One sub-module, `ranura_salida`:
  - Parameterised WIDTH.
  - Holds Q/VALID/OVF (and PAR_ERR).
  - Implements the accept/drop/overflow rules; the top holds the FSM, sh and counter.

Test Plan:
1. Reset, then DIR=0, ENB=1, READY=1, stream 32'hDDDDDDDD MSB-first → VALID=1 on edge 32 with Q=32'hDDDDDDDD, COUNT=0; VALID drops the next edge.
2. DIR=1, stream 32'hAAAAAAAA LSB-first, with ENB low for 3 cycles after bit 10 → Q=32'hAAAAAAAA on bit 32; COUNT frozen at 10 during the gap.
3. READY=0, stream 32'h66666666 then 32'h12345678 → after word 2: Q=32'h66666666, VALID=1, OVF=1; CLR → VALID=0, OVF=0.
4. READY=1, ENB held high for 96 cycles, streaming 3 words → three VALID pulses exactly 32 cycles apart, OVF=0.
5. RESET_L pulsed low mid-cycle after bit 17 → all outputs 0 asynchronously; the next full word 32'hCAFEF00D is received correctly.
6. With DESER_PARITY_EN, send 32'h00000001 with parity bit 0 → PAR_ERR=1 with VALID; then parity bit 1 → PAR_ERR=0.
